// File: rtl/reg_xfer_pkg.sv
// Shared encodings and defaults for the register-transfer initiator.
package reg_xfer_pkg;

    localparam int DEF_NUM_REGS   = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_IDX_WIDTH  = 2;

    typedef logic [1:0] op_t;
    localparam op_t OP_MOV = 2'b00;
    localparam op_t OP_LDI = 2'b01;
    localparam op_t OP_CLR = 2'b10;
    localparam op_t OP_ILL = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_OE   = 3'd1;
    localparam state_t ST_LOAD = 3'd2;
    localparam state_t ST_IMM  = 3'd3;
    localparam state_t ST_REL  = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with a global enable; all-zero when disabled.
module onehot_dec #(
    parameter int IDX_WIDTH = 2,
    parameter int NUM_REGS  = 4
) (
    input  logic                 en,
    input  logic [IDX_WIDTH-1:0] idx,
    output logic [NUM_REGS-1:0]  onehot
);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        assign onehot[i] = en && (idx == IDX_WIDTH'(i));
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-file bus initiator: sequences MOV/LDI/CLR through output/load enables and its own driver.
// Optional XFER_COUNT_EN adds a wrapping 16-bit count of completed transfers.
module reg_xfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [IDX_WIDTH-1:0]  cmd_src,
    input  logic [IDX_WIDTH-1:0]  cmd_dst,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [NUM_REGS-1:0]   reg_enable_read,
    output logic [NUM_REGS-1:0]   reg_enable_out,
    output logic [DATA_WIDTH-1:0] bus_drive,
`ifdef XFER_COUNT_EN
    output logic [15:0]           xfer_count,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t                state_q;
    logic [IDX_WIDTH-1:0]  src_q, dst_q;
    logic [DATA_WIDTH-1:0] imm_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (cmd_valid) begin
                    src_q <= cmd_src;
                    dst_q <= cmd_dst;
                    imm_q <= (cmd_op == OP_LDI) ? cmd_imm : '0;
                    case (cmd_op)
                        OP_MOV:  state_q <= (cmd_src == cmd_dst) ? ST_REL : ST_OE;
                        OP_LDI,
                        OP_CLR:  state_q <= ST_IMM;
                        default: state_q <= ST_ERR;
                    endcase
                end
                ST_OE:   state_q <= ST_LOAD;
                ST_LOAD: state_q <= ST_REL;
                ST_IMM:  state_q <= ST_REL;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Enables come purely from registered state and latched indices.
    onehot_dec #(.IDX_WIDTH(IDX_WIDTH), .NUM_REGS(NUM_REGS)) u_src_dec (
        .en     (state_q == ST_OE || state_q == ST_LOAD),
        .idx    (src_q),
        .onehot (reg_enable_out)
    );

    onehot_dec #(.IDX_WIDTH(IDX_WIDTH), .NUM_REGS(NUM_REGS)) u_dst_dec (
        .en     (state_q == ST_LOAD || state_q == ST_IMM),
        .idx    (dst_q),
        .onehot (reg_enable_read)
    );

    assign bus_drive = (state_q == ST_IMM) ? imm_q : 'z;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = (state_q == ST_REL);
    assign err       = (state_q == ST_ERR);

`ifdef XFER_COUNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clock) begin
        if (reset)
            xfer_cnt_q <= '0;
        else if (done)
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end

    assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl with a 4-register file model sharing the bus.
module tb_reg_xfer_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_src, cmd_dst;
    logic [15:0] cmd_imm;
    logic [3:0]  reg_enable_read, reg_enable_out;
    logic [15:0] bus_drive;
    logic        busy, done, err;
`ifdef XFER_COUNT_EN
    logic [15:0] xfer_count;
`endif

    int nchk = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    reg_xfer_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_src         (cmd_src),
        .cmd_dst         (cmd_dst),
        .cmd_imm         (cmd_imm),
        .reg_enable_read (reg_enable_read),
        .reg_enable_out  (reg_enable_out),
        .bus_drive       (bus_drive),
`ifdef XFER_COUNT_EN
        .xfer_count      (xfer_count),
`endif
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    // Register file model: drives the bus on its output enable, ignores loads while reset is high.
    logic [15:0] rf [4];
    logic [15:0] bus;
    logic        rf_preset;

    always_comb begin
        bus = bus_drive;
        for (int i = 0; i < 4; i++)
            if (reg_enable_out[i]) bus = rf[i];
    end

    always @(posedge clock) begin
        if (rf_preset) begin
            rf[0] <= 16'h1111; rf[1] <= 16'h2222; rf[2] <= 16'h3333; rf[3] <= 16'h4444;
        end else if (!reset) begin
            for (int i = 0; i < 4; i++)
                if (reg_enable_read[i]) rf[i] <= bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                        input logic [15:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_imm   = imm;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Every-cycle invariants.
    always @(negedge clock) begin
        if (!reset && !rf_preset) begin
            chk("oe_onehot0", {31'b0, $onehot0(reg_enable_out)}, 32'd1);
            chk("rd_onehot0", {31'b0, $onehot0(reg_enable_read)}, 32'd1);
            chk("busy_inv", {31'b0, busy}, {31'b0, ~cmd_ready});
            chk("done_err_excl", {31'b0, done & err}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [3];
        int n;

        reset = 1'b1; rf_preset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = '0; cmd_dst = '0; cmd_imm = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rd", {28'b0, reg_enable_read}, 32'd0);
        chk("rst_oe", {28'b0, reg_enable_out}, 32'd0);
        chk("rst_done_err", {30'b0, done, err}, 32'd0);
`ifdef XFER_COUNT_EN
        chk("rst_count", {16'b0, xfer_count}, 32'd0);
`endif
        reset = 1'b0; rf_preset = 1'b0;
        @(negedge clock);

        // 1: LDI r2 <= A5A5
        send(2'b01, 2'd0, 2'd2, 16'hA5A5);
        chk("ldi_c1_rd", {28'b0, reg_enable_read}, 32'h4);
        chk("ldi_c1_drv", {16'b0, bus_drive}, 32'hA5A5);
        chk("ldi_c1_done", {31'b0, done}, 32'd0);
        @(negedge clock);
        chk("ldi_c2_done", {31'b0, done}, 32'd1);
        chk("ldi_c2_rd", {28'b0, reg_enable_read}, 32'd0);
        chk("ldi_r2", {16'b0, rf[2]}, 32'hA5A5);
        @(negedge clock);
        chk("ldi_idle", {31'b0, cmd_ready}, 32'd1);

        // 2: MOV r0 <= r2
        send(2'b00, 2'd2, 2'd0, 16'h0);
        chk("mov_c1_oe", {28'b0, reg_enable_out}, 32'h4);
        chk("mov_c1_rd", {28'b0, reg_enable_read}, 32'd0);
        @(negedge clock);
        chk("mov_c2_oe", {28'b0, reg_enable_out}, 32'h4);
        chk("mov_c2_rd", {28'b0, reg_enable_read}, 32'h1);
        chk("mov_c2_done", {31'b0, done}, 32'd0);
        @(negedge clock);
        chk("mov_c3_done", {31'b0, done}, 32'd1);
        chk("mov_c3_oe", {28'b0, reg_enable_out}, 32'd0);
        chk("mov_r0", {16'b0, rf[0]}, 32'hA5A5);
        @(negedge clock);

        // 3: same-register MOV, then illegal op
        send(2'b00, 2'd1, 2'd1, 16'h0);
        chk("nop_done", {31'b0, done}, 32'd1);
        chk("nop_en", {24'b0, reg_enable_out, reg_enable_read}, 32'd0);
        chk("nop_r1", {16'b0, rf[1]}, 32'h2222);
        @(negedge clock);
        chk("nop_idle", {31'b0, cmd_ready}, 32'd1);
        send(2'b11, 2'd0, 2'd3, 16'hFFFF);
        chk("ill_err", {31'b0, err}, 32'd1);
        chk("ill_done", {31'b0, done}, 32'd0);
        chk("ill_en", {24'b0, reg_enable_out, reg_enable_read}, 32'd0);
        @(negedge clock);
        chk("ill_err_pulse", {31'b0, err}, 32'd0);
        chk("ill_idle", {31'b0, cmd_ready}, 32'd1);
        chk("ill_r3", {16'b0, rf[3]}, 32'h4444);

        // 4: three MOV r3 <= r0 with cmd_valid held
        n = 0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_src = 2'd0; cmd_dst = 2'd3;
        for (int c = 0; c < 40 && n < 3; c++) begin
            if (cmd_ready) begin
                acc[n] = c;
                n++;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        chk("b2b_count", n, 3);
        if (n == 3) begin
            chk("b2b_gap1", acc[1] - acc[0], 4);
            chk("b2b_gap2", acc[2] - acc[1], 4);
        end
        repeat (4) @(negedge clock);
        chk("b2b_r3", {16'b0, rf[3]}, 32'hA5A5);

        // 5: reset while in LOAD of MOV r2 <= r1
        send(2'b00, 2'd1, 2'd2, 16'h0);
        @(negedge clock);
        chk("rl_load_rd", {28'b0, reg_enable_read}, 32'h4);
        reset = 1'b1;
        @(negedge clock);
        chk("rl_en", {24'b0, reg_enable_out, reg_enable_read}, 32'd0);
        chk("rl_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rl_done", {31'b0, done}, 32'd0);
        chk("rl_r2", {16'b0, rf[2]}, 32'hA5A5);
        reset = 1'b0;
        @(negedge clock);
        chk("rl_after_en", {24'b0, reg_enable_out, reg_enable_read}, 32'd0);
        chk("rl_after_r2", {16'b0, rf[2]}, 32'hA5A5);

`ifdef XFER_COUNT_EN
        // 6: counter wrap and err not counted
        chk("cnt_rst", {16'b0, xfer_count}, 32'd0);
        force dut.xfer_cnt_q = 16'hFFFF;
        @(negedge clock);
        release dut.xfer_cnt_q;
        chk("cnt_pre", {16'b0, xfer_count}, 32'hFFFF);
        send(2'b01, 2'd0, 2'd1, 16'h1234);
        @(negedge clock);
        @(negedge clock);
        chk("cnt_wrap", {16'b0, xfer_count}, 32'd0);
        send(2'b11, 2'd0, 2'd1, 16'h0);
        @(negedge clock);
        chk("cnt_err", {16'b0, xfer_count}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
